code_lock_core: RTL and testbench
=================================

Name: code_lock_core

Overview:
- Parametrised lock controller core; successor to the fixed 4-digit lock datapath.
- Accepts debounced keypad digits plus enter/clear/change pulses, compares against a stored code, and counts failed attempts with timed lockout.
- Supports in-field code change (enter twice, confirm), auto-relock and entry timeout.
- Drives the state/eval/success/lock_status/rgb signals consumed by the LCD and LED drivers.

Parameters:
- CODE_LEN, 4, digits per code (1..8)
- DIGIT_W, 4, bits per digit
- DEFAULT_CODE, 16'h1234, reset code, CODE_LEN*DIGIT_W bits, first digit in MSBs
- MAX_TRIES, 3, failed attempts before lockout (1..15)
- LOCKOUT_CYC, 1250000000, lockout duration in clk cycles (10 s at 125 MHz)
- ENTRY_TO_CYC, 625000000, idle-key timeout in entry states
- OPEN_CYC, 625000000, auto-relock delay in OPEN

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle pulse: key_code is valid
- key_code  in  DIGIT_W  key value; only 0..9 accepted, 10..15 ignored
- enter  in  1  one-cycle pulse (btn0 path)
- clear  in  1  one-cycle pulse (btn1 path)
- change  in  1  one-cycle pulse, request code change
- state  out  3  FSM state encoding (below)
- digit_cnt  out  4  digits currently buffered
- eval  out  1  one-cycle pulse: comparison completed
- success  out  1  result of last eval, held until next eval
- lock_status  out  1  1 = locked
- tries_left  out  4  remaining attempts
- rgb  out  3  {R,G,B} status LED

Behaviour:
- States: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, NEW_CODE=4, CONFIRM=5, LOCKOUT=6; 7 is unreachable and decodes to IDLE.
- Reset values: state=IDLE, stored code=DEFAULT_CODE, buffer=0, digit_cnt=0, eval=0, success=0, lock_status=1, tries_left=MAX_TRIES, rgb=3'b100, all timers 0.
- Priority per cycle: clear > enter > key_valid. A digit arriving with enter or clear in the same cycle is dropped.
- Digit capture:
  - Accepted digits shift into the buffer LSB side; digit_cnt increments.
  - At digit_cnt=CODE_LEN further digits are ignored: no shift, count holds.
- IDLE: an accepted digit loads the buffer, sets digit_cnt=1, goes to ENTRY. enter, clear and change are ignored.
- ENTRY:
  - clear: buffer and digit_cnt zeroed, go to IDLE.
  - enter: go to CHECK.
  - ENTRY_TO_CYC cycles with no accepted key: buffer cleared, go to IDLE; not counted as a failure. Timer restarts on each accepted digit.
- CHECK (exactly 1 cycle):
  - match = (digit_cnt==CODE_LEN) && (buffer==stored).
  - On the exit edge: eval=1 for the next cycle only, success=match, buffer cleared.
  - match: tries_left=MAX_TRIES, go to OPEN.
  - Mismatch with tries_left>1: decrement, go to IDLE.
  - Mismatch with tries_left==1: tries_left=0, go to LOCKOUT.
  - Short entries count as mismatch.
- OPEN:
  - lock_status=0.
  - enter: relock to IDLE.
  - change: go to NEW_CODE.
  - After OPEN_CYC cycles, auto-relock to IDLE.
- NEW_CODE:
  - Digits capture normally.
  - enter with digit_cnt==CODE_LEN: latch buffer into a temp register, clear the buffer, go to CONFIRM.
  - enter with a short count: eval pulse, success=0, go to OPEN.
  - clear empties the buffer and stays in NEW_CODE.
  - Entry timeout returns to OPEN.
- CONFIRM:
  - enter with buffer==temp and a full count: stored code = temp, eval pulse, success=1, go to OPEN.
  - Any other enter: eval pulse, success=0, stored code unchanged, go to OPEN.
  - clear and timeout behave as in NEW_CODE.
  - lock_status stays 0 throughout NEW_CODE and CONFIRM.
- LOCKOUT:
  - All inputs ignored; counter runs LOCKOUT_CYC cycles.
  - Then tries_left=MAX_TRIES, go to IDLE.
- lock_status=1 in IDLE, ENTRY, CHECK and LOCKOUT.
- rgb:
  - IDLE/CHECK: 100
  - ENTRY, NEW_CODE, CONFIRM: 001
  - OPEN: 010
  - LOCKOUT: 101
- All outputs are registered. rst asserted in any state restores all reset values on the next edge, including stored code=DEFAULT_CODE. Any code change is lost on reset.
- Timers are sized by $clog2 of their parameter, saturate, and never wrap.

Test Plan:
- Correct code: rst, then keys 1,2,3,4, enter -> CHECK 1 cycle; next cycle eval=1, success=1, state=3, lock_status=0, rgb=010, tries_left=3.
- Lockout: wrong code 1,2,3,5 + enter, three times (LOCKOUT_CYC=100 in sim) -> tries_left 2,1,0; state=6, rgb=101; keys ignored for 100 cycles, then state=0, tries_left=3.
- Short and overlong entry:
  - 1,2 + enter -> success=0, tries_left=2.
  - 1,2,3,4,9 + enter -> 9 ignored, success=1.
- Code change: open, change, 5,6,7,8, enter, 5,6,7,8, enter -> eval with success=1. Relock; 1,2,3,4 then fails and 5,6,7,8 then opens. A mismatched confirm keeps 1234.
- Priority and timeout:
  - key_valid and enter in the same cycle after 1,2,3 -> digit dropped, failure.
  - clear in ENTRY -> IDLE, digit_cnt=0.
  - No key for ENTRY_TO_CYC -> IDLE, tries_left unchanged.
  - OPEN for OPEN_CYC -> lock_status=1.
- Reset mid-operation: assert rst during CONFIRM and again during LOCKOUT -> next cycle state=0, tries_left=3, stored code=1234, eval=0.

Source files
------------

// File: rtl/code_lock_core_if.sv
// Keypad/status bundle between the lock core and its keypad, LCD and LED neighbours.
// The master side drives keys and buttons; the slave side (the core) drives status.
interface code_lock_core_if #(
  parameter int DIGIT_W = 4
);
  logic               key_valid;
  logic [DIGIT_W-1:0] key_code;
  logic               enter;
  logic               clear;
  logic               change;
  logic [2:0]         state;
  logic [3:0]         digit_cnt;
  logic               eval;
  logic               success;
  logic               lock_status;
  logic [3:0]         tries_left;
  logic [2:0]         rgb;

  modport master (
    output key_valid, key_code, enter, clear, change,
    input  state, digit_cnt, eval, success, lock_status, tries_left, rgb
  );

  modport slave (
    input  key_valid, key_code, enter, clear, change,
    output state, digit_cnt, eval, success, lock_status, tries_left, rgb
  );
endinterface

// File: rtl/code_lock_core.sv
// Parametrised code lock: digit buffer, compare, retry/lockout counting,
// in-field code change with confirmation, entry timeout and auto-relock.
module code_lock_core #(
  parameter int CODE_LEN = 4,
  parameter int DIGIT_W = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYC = 1250000000,
  parameter int ENTRY_TO_CYC = 625000000,
  parameter int OPEN_CYC = 625000000
) (
  input logic clk,
  input logic rst,
  code_lock_core_if.slave bus
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int MAX_AB = (LOCKOUT_CYC > ENTRY_TO_CYC) ? LOCKOUT_CYC : ENTRY_TO_CYC;
  localparam int MAX_CYC = (MAX_AB > OPEN_CYC) ? MAX_AB : OPEN_CYC;
  localparam int TMR_W = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_CHECK    = 3'd2,
    S_OPEN     = 3'd3,
    S_NEW_CODE = 3'd4,
    S_CONFIRM  = 3'd5,
    S_LOCKOUT  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [CODE_W-1:0] tmp_q, tmp_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        tries_q, tries_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              eval_q, eval_d;
  logic              succ_q, succ_d;
  logic              lock_q, lock_d;
  logic [2:0]        rgb_q, rgb_d;

  logic              key_ok, full, match, tmr_rst;
  logic              to_entry, to_open, to_lock;
  logic [CODE_W-1:0] shifted;

  // A digit that coincides with enter or clear is dropped; 10..15 are not digits.
  assign key_ok   = bus.key_valid && (bus.key_code <= DIGIT_W'(9)) && !bus.enter && !bus.clear;
  assign full     = (cnt_q == 4'(CODE_LEN));
  assign match    = full && (buf_q == code_q);
  assign shifted  = (buf_q << DIGIT_W) | CODE_W'(bus.key_code);
  assign to_entry = (tmr_q >= TMR_W'(ENTRY_TO_CYC - 1));
  assign to_open  = (tmr_q >= TMR_W'(OPEN_CYC - 1));
  assign to_lock  = (tmr_q >= TMR_W'(LOCKOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    tmp_d   = tmp_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    eval_d  = 1'b0;
    succ_d  = succ_q;
    tmr_rst = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_ok) begin
          buf_d   = CODE_W'(bus.key_code);
          cnt_d   = 4'd1;
          tmr_rst = 1'b1;
          state_d = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (bus.clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (bus.enter) begin
          state_d = S_CHECK;
        end else if (key_ok) begin
          tmr_rst = 1'b1;
          if (!full) begin
            buf_d = shifted;
            cnt_d = cnt_q + 4'd1;
          end
        end else if (to_entry) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_CHECK: begin
        eval_d = 1'b1;
        succ_d = match;
        buf_d  = '0;
        cnt_d  = '0;
        if (match) begin
          tries_d = 4'(MAX_TRIES);
          state_d = S_OPEN;
        end else if (tries_q > 4'd1) begin
          tries_d = tries_q - 4'd1;
          state_d = S_IDLE;
        end else begin
          tries_d = '0;
          state_d = S_LOCKOUT;
        end
      end

      S_OPEN: begin
        if (bus.enter && !bus.clear) begin
          state_d = S_IDLE;
        end else if (bus.change) begin
          state_d = S_NEW_CODE;
        end else if (to_open) begin
          state_d = S_IDLE;
        end
      end

      S_NEW_CODE, S_CONFIRM: begin
        if (bus.clear) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (bus.enter) begin
          buf_d = '0;
          cnt_d = '0;
          if (state_q == S_NEW_CODE && full) begin
            tmp_d   = buf_q;
            state_d = S_CONFIRM;
          end else begin
            // Only a full confirm that repeats the first entry commits a new code.
            eval_d  = 1'b1;
            succ_d  = (state_q == S_CONFIRM) && full && (buf_q == tmp_q);
            if (succ_d) code_d = tmp_q;
            state_d = S_OPEN;
          end
        end else if (key_ok) begin
          tmr_rst = 1'b1;
          if (!full) begin
            buf_d = shifted;
            cnt_d = cnt_q + 4'd1;
          end
        end else if (to_entry) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_OPEN;
        end
      end

      S_LOCKOUT: begin
        if (to_lock) begin
          tries_d = 4'(MAX_TRIES);
          state_d = S_IDLE;
        end
      end

      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Shared timer restarts on every state change and every accepted digit, saturating at the top.
    if (tmr_rst || (state_d != state_q)) tmr_d = '0;
    else if (&tmr_q)                     tmr_d = tmr_q;
    else                                 tmr_d = tmr_q + TMR_W'(1);

    lock_d = !((state_d == S_OPEN) || (state_d == S_NEW_CODE) || (state_d == S_CONFIRM));
    case (state_d)
      S_ENTRY, S_NEW_CODE, S_CONFIRM: rgb_d = 3'b001;
      S_OPEN:                         rgb_d = 3'b010;
      S_LOCKOUT:                      rgb_d = 3'b101;
      default:                        rgb_d = 3'b100;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      tmp_q   <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      tries_q <= 4'(MAX_TRIES);
      tmr_q   <= '0;
      eval_q  <= 1'b0;
      succ_q  <= 1'b0;
      lock_q  <= 1'b1;
      rgb_q   <= 3'b100;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      tmp_q   <= tmp_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      tmr_q   <= tmr_d;
      eval_q  <= eval_d;
      succ_q  <= succ_d;
      lock_q  <= lock_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.digit_cnt   = cnt_q;
  assign bus.eval        = eval_q;
  assign bus.success     = succ_q;
  assign bus.lock_status = lock_q;
  assign bus.tries_left  = tries_q;
  assign bus.rgb         = rgb_q;

endmodule

// File: tb/tb_code_lock_core.sv
// Scoreboard bench for code_lock_core: expected eval results are queued at each
// submit and retired when the core pulses eval; status is checked directly.
module tb_code_lock_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_lock_core_if #(.DIGIT_W(4)) bus ();

  code_lock_core #(
    .CODE_LEN(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1234), .MAX_TRIES(3),
    .LOCKOUT_CYC(100), .ENTRY_TO_CYC(50), .OPEN_CYC(60)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  bit exp_q[$];
  bit exp_s;
  int n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.key_code = d;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    tick();
  endtask

  task automatic code4(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4+:4]);
  endtask

  task automatic pulse_enter();
    bus.enter = 1'b1; tick(); bus.enter = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
  endtask

  task automatic pulse_change();
    bus.change = 1'b1; tick(); bus.change = 1'b0;
  endtask

  // enter from ENTRY: one cycle of CHECK, then the result state
  task automatic submit(input bit s);
    exp_q.push_back(s);
    pulse_enter();
    chk("check_state", 32'(bus.state), 32'd2);
    chk("check_rgb", 32'(bus.rgb), 32'd4);
    tick();
  endtask

  task automatic confirm_enter(input bit s);
    exp_q.push_back(s);
    pulse_enter();
    chk("after_confirm_state", 32'(bus.state), 32'd3);
  endtask

  always @(negedge clk) begin
    if (bus.eval === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("eval_unexpected", 32'(bus.eval), 32'd0);
      end else begin
        exp_s = exp_q.pop_front();
        chk("eval_success", 32'(bus.success), 32'(exp_s));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.key_valid = 1'b0; bus.key_code = '0;
    bus.enter = 1'b0; bus.clear = 1'b0; bus.change = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_cnt", 32'(bus.digit_cnt), 32'd0);
    chk("rst_eval", 32'(bus.eval), 32'd0);
    chk("rst_success", 32'(bus.success), 32'd0);
    chk("rst_lock", 32'(bus.lock_status), 32'd1);
    chk("rst_tries", 32'(bus.tries_left), 32'd3);
    chk("rst_rgb", 32'(bus.rgb), 32'd4);
    rst = 1'b0;
    tick();

    // correct default code
    code4(16'h1234);
    chk("entry_cnt", 32'(bus.digit_cnt), 32'd4);
    chk("entry_state", 32'(bus.state), 32'd1);
    chk("entry_rgb", 32'(bus.rgb), 32'd1);
    submit(1'b1);
    chk("open_state", 32'(bus.state), 32'd3);
    chk("open_lock", 32'(bus.lock_status), 32'd0);
    chk("open_rgb", 32'(bus.rgb), 32'd2);
    chk("open_tries", 32'(bus.tries_left), 32'd3);
    pulse_enter();
    chk("relock_state", 32'(bus.state), 32'd0);
    chk("relock_lock", 32'(bus.lock_status), 32'd1);

    // short and overlong entries
    press(4'd1); press(4'd2);
    submit(1'b0);
    chk("short_tries", 32'(bus.tries_left), 32'd2);
    chk("short_state", 32'(bus.state), 32'd0);
    code4(16'h1234); press(4'd9);
    chk("overlong_cnt", 32'(bus.digit_cnt), 32'd4);
    submit(1'b1);
    chk("overlong_tries", 32'(bus.tries_left), 32'd3);
    pulse_enter();

    // digit in the same cycle as enter is dropped
    press(4'd1); press(4'd2); press(4'd3);
    exp_q.push_back(1'b0);
    bus.key_code = 4'd4; bus.key_valid = 1'b1; bus.enter = 1'b1;
    tick();
    bus.key_valid = 1'b0; bus.enter = 1'b0;
    chk("prio_state", 32'(bus.state), 32'd2);
    chk("prio_cnt", 32'(bus.digit_cnt), 32'd3);
    tick();
    chk("prio_tries", 32'(bus.tries_left), 32'd2);

    press(4'd1); pulse_clear();
    chk("clear_state", 32'(bus.state), 32'd0);
    chk("clear_cnt", 32'(bus.digit_cnt), 32'd0);
    press(4'd11);
    chk("badkey_state", 32'(bus.state), 32'd0);
    chk("badkey_cnt", 32'(bus.digit_cnt), 32'd0);

    // entry timeout: 50 cycles in ENTRY after the single digit
    press(4'd7);
    n = 0;
    do begin tick(); n++; end while (bus.state == 3'd1 && n < 200);
    chk("entry_to_cycles", 32'(n), 32'd49);
    chk("entry_to_state", 32'(bus.state), 32'd0);
    chk("entry_to_cnt", 32'(bus.digit_cnt), 32'd0);
    chk("entry_to_tries", 32'(bus.tries_left), 32'd2);

    // auto-relock after 60 cycles in OPEN
    code4(16'h1234); submit(1'b1);
    n = 0;
    do begin tick(); n++; end while (bus.lock_status == 1'b0 && n < 200);
    chk("open_to_cycles", 32'(n), 32'd60);
    chk("open_to_state", 32'(bus.state), 32'd0);

    // code change: short new code, mismatched confirm, then a real change
    code4(16'h1234); submit(1'b1);
    pulse_change();
    chk("newcode_state", 32'(bus.state), 32'd4);
    chk("newcode_lock", 32'(bus.lock_status), 32'd0);
    chk("newcode_rgb", 32'(bus.rgb), 32'd1);
    press(4'd5);
    exp_q.push_back(1'b0);
    pulse_enter();
    chk("newcode_short_state", 32'(bus.state), 32'd3);
    pulse_change(); code4(16'h9999); pulse_enter();
    chk("confirm_state", 32'(bus.state), 32'd5);
    chk("confirm_cnt", 32'(bus.digit_cnt), 32'd0);
    chk("confirm_lock", 32'(bus.lock_status), 32'd0);
    code4(16'h9998); confirm_enter(1'b0);
    pulse_enter();
    code4(16'h1234); submit(1'b1);
    chk("kept_code_state", 32'(bus.state), 32'd3);
    pulse_change(); press(4'd1); press(4'd2); pulse_clear();
    chk("newcode_clear_state", 32'(bus.state), 32'd4);
    chk("newcode_clear_cnt", 32'(bus.digit_cnt), 32'd0);
    code4(16'h5678); pulse_enter();
    code4(16'h5678); confirm_enter(1'b1);
    pulse_enter();
    code4(16'h1234); submit(1'b0);
    chk("old_code_tries", 32'(bus.tries_left), 32'd2);
    code4(16'h5678); submit(1'b1);
    chk("new_code_state", 32'(bus.state), 32'd3);
    chk("new_code_tries", 32'(bus.tries_left), 32'd3);

    // reset in CONFIRM restores the default code
    pulse_change(); code4(16'h1111); pulse_enter(); press(4'd1);
    chk("pre_rst_state", 32'(bus.state), 32'd5);
    rst = 1'b1; tick();
    chk("rst_cf_state", 32'(bus.state), 32'd0);
    chk("rst_cf_tries", 32'(bus.tries_left), 32'd3);
    chk("rst_cf_eval", 32'(bus.eval), 32'd0);
    chk("rst_cf_lock", 32'(bus.lock_status), 32'd1);
    chk("rst_cf_cnt", 32'(bus.digit_cnt), 32'd0);
    rst = 1'b0; tick();
    code4(16'h1234); submit(1'b1);
    chk("rst_default_code", 32'(bus.state), 32'd3);
    pulse_enter();

    // lockout after three failures, inputs ignored for 100 cycles
    for (int i = 2; i >= 1; i--) begin
      code4(16'h1235); submit(1'b0);
      chk("fail_tries", 32'(bus.tries_left), 32'(i));
    end
    code4(16'h1235); submit(1'b0);
    chk("lockout_state", 32'(bus.state), 32'd6);
    chk("lockout_rgb", 32'(bus.rgb), 32'd5);
    chk("lockout_tries", 32'(bus.tries_left), 32'd0);
    chk("lockout_lock", 32'(bus.lock_status), 32'd1);
    n = 0;
    do begin
      bus.key_code = 4'd1;
      bus.key_valid = (n < 20);
      bus.enter = (n == 5);
      tick(); n++;
    end while (bus.state == 3'd6 && n < 300);
    bus.key_valid = 1'b0; bus.enter = 1'b0;
    chk("lockout_cycles", 32'(n), 32'd100);
    chk("lockout_end_state", 32'(bus.state), 32'd0);
    chk("lockout_end_tries", 32'(bus.tries_left), 32'd3);
    chk("lockout_end_cnt", 32'(bus.digit_cnt), 32'd0);
    chk("lockout_end_rgb", 32'(bus.rgb), 32'd4);

    // reset during LOCKOUT
    for (int i = 0; i < 3; i++) begin
      code4(16'h4321); submit(1'b0);
    end
    chk("lockout2_state", 32'(bus.state), 32'd6);
    tick(); tick();
    rst = 1'b1; tick();
    chk("rst_lo_state", 32'(bus.state), 32'd0);
    chk("rst_lo_tries", 32'(bus.tries_left), 32'd3);
    chk("rst_lo_eval", 32'(bus.eval), 32'd0);
    rst = 1'b0;
    tick(); tick();

    chk("pending_evals", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
